// File: rtl/ddr3_pkg.sv
// ddr3_pkg
//   Shared definitions for the DDR3 user-side front end: default width
//   constants, arbiter FSM state encoding, port-index type for the default
//   port count and a helper that sizes index fields.
//   No ports (package).
package ddr3_pkg;

   localparam int unsigned DEFAULT_ADDRESS_BITWIDTH      = 15;
   localparam int unsigned DEFAULT_BANK_ADDRESS_BITWIDTH = 3;
   localparam int unsigned DEFAULT_DQ_BITWIDTH           = 16;
   localparam int unsigned DEFAULT_NUM_PORTS             = 4;

   // Index width that stays at least one bit wide for tiny counts.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   typedef logic [$clog2(DEFAULT_NUM_PORTS)-1:0] port_idx_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } arb_state_t;

endpackage

// File: rtl/ddr3_tag_fifo.sv
// ddr3_tag_fifo
//   Synchronous FIFO holding the port index of every outstanding read, so
//   returned data can be routed back in issue order. DEPTH must be a power
//   of two, at least 2. Push and pop in the same cycle are both honoured.
//   Ports:
//     clk, resetn      clock, asynchronous active-low reset
//     push, push_data  enqueue a tag
//     pop              dequeue the head tag (ignored when empty)
//     head             tag at the head of the queue
//     full, empty      occupancy flags
module ddr3_tag_fifo #(
   parameter int unsigned WIDTH = 2,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL_COUNT = (PW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    rd_ptr;
   logic [PW-1:0]    wr_ptr;
   logic [PW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == FULL_COUNT);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/ddr3_request_arbiter.sv
// ddr3_request_arbiter
//   Round-robin front end that funnels single-beat read/write requests from
//   NUM_PORTS clients onto the ddr3_memory_controller user interface, one
//   command at a time, and steers returned read data back to the issuing
//   port through an in-order tag FIFO. All outputs are registered.
//   Optional build macro: DDR_ARB_WRITE_PRIORITY_EN -- eligible writes beat
//   eligible reads; round-robin applies within the winning class.
//   Ports:
//     clk, resetn            clock, asynchronous active-low reset
//     p_req/p_we             per-port request and direction (1 = write)
//     p_addr/p_wdata         flattened per-port address and write data
//     p_gnt                  one-cycle grant pulse
//     p_rvalid/p_rdata       one-cycle read-return pulse and shared data
//     write_enable/read_enable, i_user_data_address, i_user_data
//                            controller command interface
//     ctrl_ready             controller can accept a command
//     o_user_data/ctrl_rdata_valid  controller read return
//     err_orphan             sticky: read data arrived with no tag queued
module ddr3_request_arbiter
   import ddr3_pkg::*;
#(
   parameter int unsigned NUM_PORTS             = DEFAULT_NUM_PORTS,
   parameter int unsigned ADDRESS_BITWIDTH      = DEFAULT_ADDRESS_BITWIDTH,
   parameter int unsigned BANK_ADDRESS_BITWIDTH = DEFAULT_BANK_ADDRESS_BITWIDTH,
   parameter int unsigned DQ_BITWIDTH           = DEFAULT_DQ_BITWIDTH,
   parameter int unsigned TAG_DEPTH             = 4
) (
   input  logic                                                 clk,
   input  logic                                                 resetn,
   input  logic [NUM_PORTS-1:0]                                 p_req,
   input  logic [NUM_PORTS-1:0]                                 p_we,
   input  logic [NUM_PORTS*(BANK_ADDRESS_BITWIDTH+ADDRESS_BITWIDTH)-1:0] p_addr,
   input  logic [NUM_PORTS*DQ_BITWIDTH-1:0]                     p_wdata,
   output logic [NUM_PORTS-1:0]                                 p_gnt,
   output logic [NUM_PORTS-1:0]                                 p_rvalid,
   output logic [DQ_BITWIDTH-1:0]                               p_rdata,
   output logic                                                 write_enable,
   output logic                                                 read_enable,
   output logic [BANK_ADDRESS_BITWIDTH+ADDRESS_BITWIDTH-1:0]    i_user_data_address,
   output logic [DQ_BITWIDTH-1:0]                               i_user_data,
   input  logic                                                 ctrl_ready,
   input  logic [DQ_BITWIDTH-1:0]                               o_user_data,
   input  logic                                                 ctrl_rdata_valid,
   output logic                                                 err_orphan
);

   localparam int unsigned AW = BANK_ADDRESS_BITWIDTH + ADDRESS_BITWIDTH;
   localparam int unsigned IW = idx_width(NUM_PORTS);

   arb_state_t           state, state_n;
   logic [IW-1:0]        ptr, ptr_n;
   logic [IW-1:0]        win, win_n;
   logic [IW-1:0]        pick;
   logic [NUM_PORTS-1:0] gnt_n;
   logic                 we_n, re_n;
   logic [AW-1:0]        addr_n;
   logic [DQ_BITWIDTH-1:0] data_n;
   logic [NUM_PORTS-1:0] eligible;
   logic [NUM_PORTS-1:0] cand;
   logic                 tag_push;
   logic                 tag_full;
   logic                 tag_empty;
   logic [IW-1:0]        tag_head;

   // First set bit of mask searching upward from the port after last.
   // Scanning from the far end and overwriting leaves the nearest hit.
   function automatic logic [IW-1:0] rr_pick(input logic [NUM_PORTS-1:0] mask,
                                             input logic [IW-1:0]        last);
      logic [IW-1:0] sel;
      int unsigned   idx;
      sel = last;
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
         idx = (32'(last) + (NUM_PORTS - i)) % NUM_PORTS;
         if (mask[IW'(idx)]) begin
            sel = IW'(idx);
         end
      end
      return sel;
   endfunction

   // Reads need a free tag slot; writes are always eligible.
   assign eligible = p_req & (p_we | {NUM_PORTS{!tag_full}});

`ifdef DDR_ARB_WRITE_PRIORITY_EN
   logic [NUM_PORTS-1:0] wr_eligible;
   assign wr_eligible = eligible & p_we;
   assign cand        = (|wr_eligible) ? wr_eligible : eligible;
`else
   assign cand = eligible;
`endif

   assign pick     = rr_pick(cand, ptr);
   assign tag_push = (state == ISSUE) && read_enable;

   always_comb begin
      state_n = state;
      ptr_n   = ptr;
      win_n   = win;
      gnt_n   = '0;
      we_n    = 1'b0;
      re_n    = 1'b0;
      addr_n  = i_user_data_address;
      data_n  = i_user_data;
      case (state)
         IDLE: begin
            // Command outputs are loaded here so they are already
            // registered for the single ISSUE cycle.
            if ((|cand) && ctrl_ready) begin
               win_n        = pick;
               gnt_n[pick]  = 1'b1;
               we_n         = p_we[pick];
               re_n         = !p_we[pick];
               addr_n       = p_addr[32'(pick)*AW +: AW];
               data_n       = p_wdata[32'(pick)*DQ_BITWIDTH +: DQ_BITWIDTH];
               state_n      = ISSUE;
            end
         end
         ISSUE: begin
            ptr_n   = win;
            state_n = WAIT;
         end
         WAIT: begin
            if (ctrl_ready) begin
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state               <= IDLE;
         ptr                 <= IW'(NUM_PORTS - 1);
         win                 <= '0;
         p_gnt               <= '0;
         write_enable        <= 1'b0;
         read_enable         <= 1'b0;
         i_user_data_address <= '0;
         i_user_data         <= '0;
      end else begin
         state               <= state_n;
         ptr                 <= ptr_n;
         win                 <= win_n;
         p_gnt               <= gnt_n;
         write_enable        <= we_n;
         read_enable         <= re_n;
         i_user_data_address <= addr_n;
         i_user_data         <= data_n;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         p_rvalid   <= '0;
         p_rdata    <= '0;
         err_orphan <= 1'b0;
      end else begin
         p_rvalid <= '0;
         if (ctrl_rdata_valid) begin
            if (tag_empty) begin
               err_orphan <= 1'b1;
            end else begin
               p_rvalid[tag_head] <= 1'b1;
               p_rdata            <= o_user_data;
            end
         end
      end
   end

   ddr3_tag_fifo #(
      .WIDTH (IW),
      .DEPTH (TAG_DEPTH)
   ) u_tag_fifo (
      .clk       (clk),
      .resetn    (resetn),
      .push      (tag_push),
      .push_data (win),
      .pop       (ctrl_rdata_valid),
      .head      (tag_head),
      .full      (tag_full),
      .empty     (tag_empty)
   );

endmodule

// File: doc/ddr3_request_arbiter.md
# ddr3_request_arbiter

Multi-port front end for `ddr3_memory_controller`. It accepts single-beat write and read requests from `NUM_PORTS` user clients and arbitrates between them round-robin. It issues one command at a time on the controller's `write_enable`/`read_enable` user interface and routes returned read data back to the issuing port in order, using a tag FIFO. It sits between the user logic (loopback tester, DMA engines) and `ddr3_memory_controller`, replacing direct user drive of that interface.

## Interface
- `NUM_PORTS`, 4: number of requesters, 2..8.
- `ADDRESS_BITWIDTH`, 15: DDR row/column address bits.
- `BANK_ADDRESS_BITWIDTH`, 3: bank bits.
- `DQ_BITWIDTH`, 16: user data width.
- `TAG_DEPTH`, 4: maximum outstanding reads, power of 2.
- Let AW = `BANK_ADDRESS_BITWIDTH` + `ADDRESS_BITWIDTH`.

Ports:
- `clk`, in, 1: single clock, all logic is rising-edge.
- `resetn`, in, 1: asynchronous active-low reset.
- `p_req`, in, `NUM_PORTS`: per-port request, held high until granted.
- `p_we`, in, `NUM_PORTS`: 1 = write, 0 = read.
- `p_addr`, in, `NUM_PORTS`*AW: flattened addresses; port k occupies slice [k*AW +: AW].
- `p_wdata`, in, `NUM_PORTS`*`DQ_BITWIDTH`: flattened write data.
- `p_gnt`, out, `NUM_PORTS`: one-cycle grant pulse.
- `p_rvalid`, out, `NUM_PORTS`: one-cycle read-data pulse.
- `p_rdata`, out, `DQ_BITWIDTH`: shared read data bus, valid when any `p_rvalid` bit is high.
- `write_enable`, out, 1: controller write strobe.
- `read_enable`, out, 1: controller read strobe.
- `i_user_data_address`, out, AW: controller address.
- `i_user_data`, out, `DQ_BITWIDTH`: controller write data.
- `ctrl_ready`, in, 1: controller can accept a command.
- `o_user_data`, in, `DQ_BITWIDTH`: controller read data.
- `ctrl_rdata_valid`, in, 1: `o_user_data` is valid this cycle.
- `err_orphan`, out, 1: sticky flag, set when read data arrives with no outstanding tag.

## Operation
- FSM states are IDLE, ISSUE and WAIT.
- IDLE:
  - A port is eligible when `p_req` is high, and, for a read, the tag FIFO is not full.
  - If any port is eligible and `ctrl_ready` is high, pick the winner round-robin, starting from the port after the last winner. Move to ISSUE.
  - Ineligible ports are skipped; a blocked read never stalls a write.
- ISSUE, one cycle:
  - Assert `p_gnt[w]`.
  - Assert `write_enable` or `read_enable` per `p_we[w]`.
  - Drive `i_user_data_address` and `i_user_data` from port w's registered values.
  - On a read, push w into the tag FIFO.
  - Update the round-robin pointer to w. Go to WAIT.
- WAIT:
  - Stay at least one cycle, then return to IDLE on the first cycle `ctrl_ready` is high.
  - The minimum cycle lets the granted port drop `p_req` before re-sampling.
- Read return:
  - On `ctrl_rdata_valid`, pop the FIFO head h. Next cycle assert `p_rvalid[h]`, with `p_rdata` = `o_user_data`.
  - Push and pop in the same cycle are both honoured; occupancy is unchanged.
  - `ctrl_rdata_valid` with the FIFO empty sets `err_orphan`, and no `p_rvalid` is asserted.
- Reset values: all outputs 0, FSM in IDLE, pointer = `NUM_PORTS`-1 (so port 0 wins first), FIFO empty, `err_orphan` 0.
- Reset mid-operation discards in-flight reads; the controller's late read data then sets `err_orphan`.
- `i_user_data_address` and `i_user_data` hold their last values outside ISSUE.

## Timing
- Request sampled in IDLE at edge N: grant and strobe are high in cycle N+1, and WAIT is entered at N+2.
- Peak throughput is one command per 3 cycles with `ctrl_ready` constantly high.
- Read-data latency through the block is exactly 1 cycle.
- All outputs are registered. No combinational path from `p_*` inputs to controller outputs.

## Configuration
- `DDR_ARB_WRITE_PRIORITY_EN`
  - Defined: eligible writes always beat eligible reads. Round-robin applies within writes, then within reads. The pointer advances only among the class that won.
  - Undefined: pure round-robin over all eligible ports, regardless of direction.

## Structure
- Shared package `ddr3_pkg`:
  - FSM state enum (IDLE/ISSUE/WAIT).
  - Default width constants (ADDRESS_BITWIDTH 15, BANK_ADDRESS_BITWIDTH 3, DQ_BITWIDTH 16).
  - Port-index type sized by `$clog2(NUM_PORTS)`.
- Sub-module `ddr3_tag_fifo`:
  - Synchronous FIFO, width `$clog2(NUM_PORTS)`, depth `TAG_DEPTH`.
  - Outputs full and empty flags.
  - Supports simultaneous push and pop.

## Test plan
- Single write: port 2 req, we=1, addr 0x12345, data 0xBEEF → `p_gnt[2]` and `write_enable` high together 1 cycle later, address 0x12345, data 0xBEEF. No `p_rvalid`.
- Round-robin: all 4 ports request continuously, macro undefined → grant order 0,1,2,3,0, with grants 3 cycles apart.
- Read routing: ports 1 then 3 read. Controller returns 0xAAAA, then 0x5555 → `p_rvalid[1]` with 0xAAAA, then `p_rvalid[3]` with 0x5555, each 1 cycle after `ctrl_rdata_valid`.
- Tag full: 4 reads outstanding, port 0 read plus port 1 write pending → port 1 granted, port 0 held. Port 0 is granted only after the next `ctrl_rdata_valid`.
- Write priority: macro defined, ports 0 (read) and 1 (write) request together → port 1 granted first. Macro undefined → port 0 granted first.
- Orphan and reset: `ctrl_rdata_valid` with the FIFO empty → `err_orphan`=1 and stays set. Asserting `resetn`=0 mid-WAIT → all outputs 0 asynchronously, and `err_orphan` clears.
